// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   F3_*        funct3 codes for the supported RISC-V load/store widths
//   state_t     responder FSM states
//   access_err  request-rejection decode
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Returns 1 when a request must be rejected.
  // The caller reduces the address to its byte lane and an in-range flag,
  // so this helper stays independent of memory depth and data width.
  // Unsigned widths (BU/HU) exist only for loads.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lane,
                                      input logic       in_range);
    logic err;
    err = ~in_range;
    case (funct3)
      F3_B:    ;
      F3_H:    if (lane[0]) err = 1'b1;
      F3_W:    if (lane != 2'b00) err = 1'b1;
      F3_BU:   if (we) err = 1'b1;
      F3_HU:   if (we || lane[0]) err = 1'b1;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder (purely combinational).
// Ports:
//   word        current memory word at the addressed index
//   wdata       right-aligned store data
//   lane        byte lane (addr[1:0])
//   funct3      access type
//   load_data   extracted and sign/zero-extended load result
//   store_word  word with the store data merged into the selected lanes
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       lane,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_word
);

  localparam int LANES = WIDTH / 8;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [LANES-1:0] byte_en;
  logic [WIDTH-1:0] wdata_rep;

  always_comb begin
    byte_sel  = word[8*lane +: 8];
    half_sel  = word[16*lane[1] +: 16];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase
  end

  // Replicating the store data across the word means each lane can simply
  // pick its own slice; the byte enables decide which lanes take it.
  always_comb begin
    byte_en   = '0;
    wdata_rep = wdata;
    case (funct3)
      F3_B: begin
        byte_en   = LANES'(1) << lane;
        wdata_rep = {(WIDTH/8){wdata[7:0]}};
      end
      F3_H: begin
        byte_en   = LANES'(3) << {lane[1], 1'b0};
        wdata_rep = {(WIDTH/16){wdata[15:0]}};
      end
      F3_W: begin
        byte_en   = '1;
        wdata_rep = wdata;
      end
      default: begin
        byte_en   = '0;
        wdata_rep = wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign store_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8] : word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: the target end of the CPU load/store port.
// Accepts one request at a time, waits LATENCY cycles, then performs the
// byte/half/word access and presents the result until it is consumed.
// Ports:
//   iClk, iRst            clock (rising edge), async active-high reset
//   iReqValid/oReqReady   request handshake
//   iWe, iAddr, iFunct3,  request fields (store flag, byte address,
//   iWData                access type, right-aligned store data)
//   oRspValid/iRspReady   response handshake
//   oRData, oErr          load result (0 for stores/errors), reject flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic             iWe,
  input  logic [WIDTH-1:0] iAddr,
  input  logic [2:0]       iFunct3,
  input  logic [WIDTH-1:0] iWData,
  output logic             oRspValid,
  input  logic             iRspReady,
  output logic [WIDTH-1:0] oRData,
  output logic             oErr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WIDTH-1:0] DEPTH_LIMIT = WIDTH'(DEPTH_WORDS);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic             we_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [2:0]       funct3_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [WIDTH-1:0] rd_word_reg;
  logic [WIDTH-1:0] rdata_reg;
  logic             err_reg;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic             in_range;
  logic             req_err;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] store_word;

  assign accept   = (state_reg == IDLE) && iReqValid;
  assign commit   = (state_reg == WAIT) && (cnt_reg == '0);
  assign in_range = {2'b00, addr_reg[WIDTH-1:2]} < DEPTH_LIMIT;
  assign req_err  = access_err(we_reg, funct3_reg, addr_reg[1:0], in_range);

  dmem_lane_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .word      (rd_word_reg),
    .wdata     (wdata_reg),
    .lane      (addr_reg[1:0]),
    .funct3    (funct3_reg),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    oReqReady  = 1'b0;
    oRspValid  = 1'b0;
    case (state_reg)
      IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid) state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = RESP;
      end
      RESP: begin
        oRspValid = 1'b1;
        if (iRspReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      funct3_reg <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg    <= CW'(LATENCY - 1);
        we_reg     <= iWe;
        addr_reg   <= iAddr;
        funct3_reg <= iFunct3;
        wdata_reg  <= iWData;
      end else if (state_reg == WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CW'(1);
      end

      if (commit) begin
        err_reg   <= req_err;
        rdata_reg <= (req_err || we_reg) ? '0 : load_data;
      end else if (state_reg == RESP && iRspReady) begin
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end
    end
  end

  assign oRData = rdata_reg;
  assign oErr   = err_reg;

  // The old word is read on the accept edge; nothing else touches memory
  // while the request is outstanding, so it is still valid at commit for
  // both the load extract and the store merge.
  always_ff @(posedge iClk) begin
    if (accept)
      rd_word_reg <= mem[iAddr[AW+1:2]];
    if (commit && we_reg && !req_err)
      mem[addr_reg[AW+1:2]] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iWe = 1'b0;
  logic [31:0] iAddr = '0;
  logic [2:0]  iFunct3 = '0;
  logic [31:0] iWData = '0;
  logic        oRspValid;
  logic        iRspReady = 1'b0;
  logic [31:0] oRData;
  logic        oErr;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 iClk = ~iClk;

  dmem_responder #(
    .WIDTH(32), .DEPTH_WORDS(256), .LATENCY(LAT)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iReqValid(iReqValid),
    .oReqReady(oReqReady),
    .iWe      (iWe),
    .iAddr    (iAddr),
    .iFunct3  (iFunct3),
    .iWData   (iWData),
    .oRspValid(oRspValid),
    .iRspReady(iRspReady),
    .oRData   (oRData),
    .oErr     (oErr)
  );

  // Drive one request from IDLE; returns #1 after the accept edge.
  task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err);
    exp_t e;
    @(negedge iClk);
    total_cnt++;
    if (oReqReady !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", oReqReady);
    else pass_cnt++;
    iReqValid = 1'b1;
    iWe       = we;
    iFunct3   = f3;
    iAddr     = addr;
    iWData    = wdata;
    e.data    = exp_data;
    e.err     = exp_err;
    sb_q.push_back(e);
    @(posedge iClk);
    #1;
    iReqValid = 1'b0;
  endtask

  // Wait for the response, hold it for 'hold' cycles, compare, handshake.
  task automatic await_rsp(input string name, input int hold);
    int          cyc;
    exp_t        e;
    logic [31:0] d0;
    logic        e0;
    cyc = 0;
    while (oRspValid !== 1'b1 && cyc < 20) begin
      total_cnt++;
      if (oReqReady !== 1'b0) $display("FAIL %s ready_in_wait: got %b want 0", name, oReqReady);
      else pass_cnt++;
      @(posedge iClk);
      #1;
      cyc++;
    end
    total_cnt++;
    if (oRspValid !== 1'b1 || cyc != LAT) begin
      $display("FAIL %s latency: got %0d cycles (valid=%b) want %0d", name, cyc, oRspValid, LAT);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    pass_cnt++;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
      return;
    end
    e  = sb_q.pop_front();
    d0 = oRData;
    e0 = oErr;
    for (int i = 0; i < hold; i++) begin
      @(posedge iClk);
      #1;
      total_cnt++;
      if (oRspValid !== 1'b1 || oReqReady !== 1'b0 || oRData !== d0 || oErr !== e0)
        $display("FAIL %s hold%0d: valid=%b ready=%b data=%h err=%b want 1 0 %h %b",
                 name, i, oRspValid, oReqReady, oRData, oErr, d0, e0);
      else pass_cnt++;
    end
    total_cnt++;
    if (oRData !== e.data || oErr !== e.err)
      $display("FAIL %s data: got %h err=%b want %h err=%b", name, oRData, oErr, e.data, e.err);
    else begin
      pass_cnt++;
      $display("txn %s: data=%h err=%b", name, oRData, oErr);
    end
    iRspReady = 1'b1;
    @(posedge iClk);
    #1;
    iRspReady = 1'b0;
    total_cnt++;
    if (oRspValid !== 1'b0 || oReqReady !== 1'b1)
      $display("FAIL %s after_handshake: valid=%b ready=%b want 0 1", name, oRspValid, oReqReady);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge iClk);
    #1;
    total_cnt++;
    if (oReqReady !== 1'b1 || oRspValid !== 1'b0 || oRData !== 32'h0 || oErr !== 1'b0)
      $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b want 1 0 0 0",
               oReqReady, oRspValid, oRData, oErr);
    else pass_cnt++;
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_basic();
    send_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    await_rsp("sw_10", 0);
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    await_rsp("lw_10", 0);
  endtask

  task automatic test_extensions();
    send_req(1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    await_rsp("lb_13", 0);
    send_req(1'b0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    await_rsp("lbu_13", 0);
    send_req(1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    await_rsp("lh_12", 0);
    send_req(1'b0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    await_rsp("lhu_10", 0);
  endtask

  task automatic test_partial_store();
    send_req(1'b1, 3'd0, 32'h11, 32'h00000055, 32'h0, 1'b0);
    await_rsp("sb_11", 0);
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    await_rsp("lw_after_sb", 0);
    send_req(1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0, 1'b0);
    await_rsp("sh_12", 0);
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    await_rsp("lw_after_sh", 0);
  endtask

  task automatic test_errors();
    send_req(1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1);
    await_rsp("lw_misaligned", 0);
    send_req(1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
    await_rsp("sh_misaligned", 0);
    send_req(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
    await_rsp("lw_out_of_range", 0);
    send_req(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
    await_rsp("illegal_f3", 0);
    send_req(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    await_rsp("store_bu", 0);
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    await_rsp("lw_after_errors", 0);
  endtask

  // A competing store is held on the request port for the whole response;
  // it must never be accepted, which the follow-up load confirms.
  task automatic test_back_to_back();
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    iReqValid = 1'b1;
    iWe       = 1'b1;
    iFunct3   = 3'd2;
    iAddr     = 32'h10;
    iWData    = 32'h0BAD0BAD;
    await_rsp("lw_backpressure", 5);
    iReqValid = 1'b0;
    send_req(1'b0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    await_rsp("lw_no_stray_store", 0);
  endtask

  task automatic test_reset_mid();
    send_req(1'b1, 3'd2, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0);
    await_rsp("sw_20", 0);
    send_req(1'b1, 3'd2, 32'h20, 32'h00000001, 32'h0, 1'b0);
    #1;
    iRst = 1'b1;
    #1;
    total_cnt++;
    if (oReqReady !== 1'b1 || oRspValid !== 1'b0 || oRData !== 32'h0 || oErr !== 1'b0)
      $display("FAIL reset_in_wait: ready=%b valid=%b data=%h err=%b want 1 0 0 0",
               oReqReady, oRspValid, oRData, oErr);
    else begin
      pass_cnt++;
      $display("txn reset_in_wait: outputs at reset values");
    end
    sb_q.delete();
    @(negedge iClk);
    iRst = 1'b0;
    send_req(1'b0, 3'd2, 32'h20, 32'h0, 32'hAAAAAAAA, 1'b0);
    await_rsp("lw_20_after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extensions();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the CPU's load/store port. It accepts one request at a time over a valid/ready handshake and performs the RISC-V byte, half and word access with sign or zero extension. It returns the result over a second valid/ready handshake after a programmable number of wait cycles. It sits beside top's core as the target end of the load/store interface and lets the datapath be exercised against a memory with non-zero latency.

Parameters:
WIDTH, 32, data and address width in bits.
DEPTH_WORDS, 256, number of WIDTH-bit words in the memory array.
LATENCY, 2, cycles from request acceptance to oRspValid rising; must be >= 1.

Ports:
iClk  in  1  clock, rising edge.
iRst  in  1  reset, asynchronous, active-high.
iReqValid  in  1  request present.
oReqReady  out  1  responder can accept a request.
iWe  in  1  1 = store, 0 = load.
iAddr  in  WIDTH  byte address.
iFunct3  in  3  access type: 0=B, 1=H, 2=W, 4=BU, 5=HU.
iWData  in  WIDTH  store data, right-aligned.
oRspValid  out  1  response present.
iRspReady  in  1  consumer accepts the response.
oRData  out  WIDTH  load result; 0 for stores and errors.
oErr  out  1  request was rejected (misaligned, out of range, or illegal funct3).

Behaviour:
- Reset (async assert, sync release): state IDLE; oReqReady=1; oRspValid=0; oRData=0; oErr=0. Memory contents are not reset.
- FSM states:
  - IDLE: oReqReady=1. When iReqValid&oReqReady, capture iWe, iAddr, iFunct3 and iWData, load the wait counter with LATENCY-1, and go to WAIT.
  - WAIT: oReqReady=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP. oRspValid rises exactly LATENCY cycles after the accept edge.
  - RESP: oRspValid=1 and oReqReady=0. oRData and oErr are held stable until iRspReady=1. On the handshake, go to IDLE.
- Turnaround: one cycle minimum in IDLE between transactions. There is no request acceptance in the same cycle as a response handshake.
- Access decode uses word index = addr[WIDTH-1:2] and byte lane = addr[1:0].
- Loads:
  - B and BU extract the byte at the addressed lane.
  - H and HU extract the halfword at lane addr[1]*2.
  - W returns the full word.
  - B and H sign-extend; BU and HU zero-extend.
- Stores:
  - SB writes only the addressed byte lane.
  - SH writes lanes {addr[1]*2, addr[1]*2+1}.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Error conditions, all giving oErr=1 and oRData=0 with no memory write:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - word index >= DEPTH_WORDS.
  - funct3 in {3,6,7}.
  - a store with funct3 in {4,5}.
- Store response: oRData=0, oErr=0.
- Write commit happens only at the WAIT→RESP transition. Reset asserted at any earlier point drops the transaction with no memory change.
- Reset during RESP clears oRspValid immediately; the already-committed write remains.
- Inputs are ignored outside IDLE, and iRspReady is ignored outside RESP.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - the state enum {IDLE, WAIT, RESP}.
  - a function returning the error flag from (we, funct3, addr).
- Sub-module dmem_lane_align (combinational) provides:
  - load extraction and extension from (word, lane, funct3).
  - store merge from (old word, wdata, lane, funct3).
- dmem_responder holds the FSM, the counter, the capture registers and the memory array.

Test Plan:
- Basic store/load: SW 0xDEADBEEF @0x10, then LW @0x10 → oRData=0xDEADBEEF, oErr=0. oRspValid rises exactly 2 cycles after each accept; oReqReady=0 during WAIT and RESP.
- Load extensions:
  - LB @0x13 → 0xFFFFFFDE.
  - LBU @0x13 → 0x000000DE.
  - LH @0x12 → 0xFFFFDEAD.
  - LHU @0x10 → 0x0000BEEF.
- Partial store: SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF. SH 0x1234 @0x12, then LW @0x10 → 0x123455EF.
- Errors:
  - LW @0x12 → oErr=1, oRData=0.
  - SH @0x11 → oErr=1.
  - LW @0x400 → oErr=1.
  - LW @0x10 afterwards still returns 0x123455EF.
- Backpressure: hold iRspReady=0 for 5 cycles in RESP → oRspValid=1 with oRData and oErr constant. A new iReqValid is not accepted until IDLE follows the handshake.
- Reset mid-operation:
  - SW 0xAAAAAAAA @0x20, then SW 0x00000001 @0x20 with iRst pulsed in WAIT → outputs at reset values the same cycle.
  - A subsequent LW @0x20 → 0xAAAAAAAA.
